alu_flags_seq: RTL
==================

# alu_flags_seq

Parametrised sequential arithmetic unit with an architectural NZCV flag register and a start/done handshake. It generalises the combinational subtractor-with-flags into a clocked datapath. Supported operations are ADD, SUB, ADC, SBC, CMP and a multi-cycle unsigned shift-add MUL. It sits between the lab control FSM, which issues `start`/`op`, and the register/display path, which consumes `R` and the flags.

## Interface
- `N`, default 4: operand and result width; legal values N ≥ 2.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only at a rising edge while idle (`busy`=0).
- `op` in 3: operation code, sampled with `start`.
- `A` in N: first operand (minuend), sampled with `start`.
- `B` in N: second operand (subtrahend), sampled with `start`.
- `busy` out 1: high while a MUL is iterating.
- `done` out 1: one-cycle pulse when the result and flags are valid.
- `R` out N: registered result.
- `flag_n` out 1: negative flag, registered.
- `flag_z` out 1: zero flag, registered.
- `flag_c` out 1: carry flag, registered.
- `flag_v` out 1: overflow flag, registered.

## Operation
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A+~B+1.
  - 010 ADC: A+B+flag_c.
  - 011 SBC: A+~B+flag_c.
  - 100 CMP: same arithmetic as SUB; writes flags only, R unchanged.
  - 101 MUL: unsigned A×B.
  - 110 and 111 reserved: `done` pulses; R and all flags unchanged.
- Add/sub arithmetic is computed in N+1 bits. R = sum[N-1:0].
- Add/sub flags:
  - C = sum[N]. For SUB/SBC/CMP, C=1 means no borrow (A ≥ B unsigned).
  - V for ADD/ADC: A[N-1]==B[N-1] and R[N-1]!=A[N-1].
  - V for SUB/SBC/CMP: A[N-1]!=B[N-1] and R[N-1]!=A[N-1].
  - N = R[N-1].
  - Z = (R == 0). For CMP, Z is computed from the unwritten difference.
- MUL:
  - 2N-bit product P, computed by shift-add: one multiplier bit per cycle, N iterations.
  - R = P[N-1:0].
  - C = (P[2N-1:N] != 0).
  - V = 0.
  - N and Z are taken from R.
- State machine:
  - IDLE: on `start`, single-cycle ops (including reserved opcodes) complete at that edge and stay in IDLE. MUL latches A and B, clears the accumulator and counter, and goes to MULT.
  - MULT: one iteration per edge. After the Nth iteration, write R and the flags, pulse `done`, and return to IDLE.
- `start` while `busy`=1 is ignored; it is neither queued nor does it disturb the operation in flight.
- Operand or `op` changes after acceptance have no effect.
- Flags and R hold their values between operations. Flags persist across ops, so ADC/SBC chains work for multi-word arithmetic.

## Timing
- Reset (asynchronous, immediate): R=0, all flags=0, `busy`=0, `done`=0, state IDLE, counter=0.
- Reset mid-MUL aborts the operation; no `done` is produced and the flags are cleared.
- Single-cycle op accepted at edge t0:
  - R and flags change at t0.
  - `done`=1 for exactly the cycle after t0.
  - A new `start` may be accepted at t0+1 (back-to-back, throughput 1 op/cycle).
- MUL accepted at edge t0:
  - `busy` rises after t0.
  - Iterations occur on edges t1..tN.
  - R and flags are written at tN; `busy` falls and `done`=1 during the cycle after tN.
  - Latency: N+1 edges.
  - The next `start` can be accepted at tN+1.
- `done` never asserts without an accepted `start`, and never lasts more than one cycle.

## Test plan
- N=4, ADD 7+1 -> R=8, N=1, Z=0, C=0, V=1; `done` high exactly one cycle after the accepting edge.
- SUB 3−5 -> R=14, N=1, C=0, V=0. Then SUB 5−5 -> R=0, Z=1, C=1, V=0. Both issued back-to-back on consecutive cycles.
- Carry chain: ADD 15+1 -> R=0, Z=1, C=1. Then ADC 0+0 -> R=1, C=0, Z=0. Then SBC 0−0 with C=0 -> R=15, N=1, C=0.
- With R=8 held, CMP 9,9 -> R stays 8, Z=1, C=1, N=0, V=0. Reserved op 110 -> `done` pulse, R=8, flags unchanged.
- MUL 7×3:
  - `busy` high 4 cycles; then R=5, C=1, V=0, N=0, Z=0, `done` one cycle.
  - A `start` with ADD pulsed during `busy` is ignored.
  - Separately, MUL 15×15 -> R=1, C=1.
- Reset asserted asynchronously in the 2nd MUL iteration -> R and flags are 0 and `busy`=0 before the next edge. No `done` follows. A fresh ADD 2+2 then gives R=4.

Source files
------------

// File: rtl/alu_flags_seq_if.sv
// Request/response bundle between the control FSM (master) and the ALU (slave).
interface alu_flags_seq_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] R;
  logic         flag_n;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;

  modport master (
    output start, op, A, B,
    input  busy, done, R, flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, R, flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/alu_flags_seq.sv
// Sequential ALU with NZCV flag register: single-cycle add/sub family,
// N-cycle shift-add multiply, start/done handshake.
module alu_flags_seq #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  alu_flags_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned PW = 2 * N;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic {IDLE, MULT} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    r_q, r_d;
  logic            fn_q, fn_d, fz_q, fz_d, fc_q, fc_d, fv_q, fv_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [PW-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [N-1:0]    b_eff_c;
  logic            cin_c;
  logic [N:0]      sum_c;
  logic            v_c;
  logic [PW-1:0]   acc_next_c;

  // Add/sub datapath: subtraction is A + ~B + carry-in, computed in N+1 bits.
  always_comb begin
    b_eff_c = bus.B;
    cin_c   = 1'b0;
    case (bus.op)
      OP_SUB, OP_CMP: begin b_eff_c = ~bus.B; cin_c = 1'b1; end
      OP_ADC:         cin_c = fc_q;
      OP_SBC:         begin b_eff_c = ~bus.B; cin_c = fc_q; end
      default:        ;
    endcase
    sum_c = {1'b0, bus.A} + {1'b0, b_eff_c} + (N+1)'(cin_c);
    // Overflow when both addends share a sign that the result does not.
    v_c   = (bus.A[N-1] == b_eff_c[N-1]) && (sum_c[N-1] != bus.A[N-1]);
  end

  // One shift-add step: accumulate the shifted multiplicand if the multiplier LSB is set.
  always_comb begin
    acc_next_c = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    fn_d     = fn_q;
    fz_d     = fz_q;
    fc_d     = fc_q;
    fv_d     = fv_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
              r_d    = sum_c[N-1:0];
              fn_d   = sum_c[N-1];
              fz_d   = (sum_c[N-1:0] == '0);
              fc_d   = sum_c[N];
              fv_d   = v_c;
              done_d = 1'b1;
            end
            OP_CMP: begin
              fn_d   = sum_c[N-1];
              fz_d   = (sum_c[N-1:0] == '0);
              fc_d   = sum_c[N];
              fv_d   = v_c;
              done_d = 1'b1;
            end
            OP_MUL: begin
              acc_d    = '0;
              mcand_d  = PW'(bus.A);
              mplier_d = bus.B;
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = MULT;
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      MULT: begin
        acc_d    = acc_next_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          r_d     = acc_next_c[N-1:0];
          fn_d    = acc_next_c[N-1];
          fz_d    = (acc_next_c[N-1:0] == '0);
          fc_d    = (acc_next_c[PW-1:N] != '0);
          fv_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      r_q      <= '0;
      fn_q     <= 1'b0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      fv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      fn_q     <= fn_d;
      fz_q     <= fz_d;
      fc_q     <= fc_d;
      fv_q     <= fv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.R      = r_q;
  assign bus.flag_n = fn_q;
  assign bus.flag_z = fz_q;
  assign bus.flag_c = fc_q;
  assign bus.flag_v = fv_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule
